// File: rtl/pc_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_sequencer_if
// Description : Bundles the instruction-memory handshake, the datapath
//               framing signals and the run-control signals of the fetch
//               sequencer.
//               master modport : sequencer side (drives PC, requests, status)
//               slave  modport : memory / datapath / control side
//               Optional macro MISALIGN_TRAP_EN adds the misalign_trap signal.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Signals:
//   imem_req     seq->mem   fetch request, held until imem_gnt
//   imem_addr    seq->mem   fetch address (= pc)
//   imem_gnt     mem->seq   memory accepts the request this cycle
//   imem_rvalid  mem->seq   read data valid
//   imem_rdata   mem->seq   instruction word
//   instr        seq->dp    latched instruction
//   instr_valid  seq->dp    instr valid, held until exec_done
//   exec_done    dp->seq    current instruction retires
//   branch       dp->seq    instruction is a branch
//   zero_flag    dp->seq    ALU zero result
//   pc_branch    dp->seq    branch target
//   pc           seq->dp    current PC
//   pc_src       seq->dp    registered (branch & zero_flag) of last retirement
//   halt_req     ctl->seq   stop after the current instruction retires
//   resume       ctl->seq   leave HALT
//   halted       seq->ctl   sequencer is halted
//   fetch_err    seq->ctl   sticky fetch timeout fault
//   misalign_trap seq->ctl  sticky misaligned-branch trap (MISALIGN_TRAP_EN)
// ============================================================================
interface pc_fetch_sequencer_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic [31:0]     instr;
    logic            instr_valid;
    logic            exec_done;
    logic            branch;
    logic            zero_flag;
    logic [XLEN-1:0] pc_branch;
    logic [XLEN-1:0] pc;
    logic            pc_src;
    logic            halt_req;
    logic            resume;
    logic            halted;
    logic            fetch_err;
`ifdef MISALIGN_TRAP_EN
    logic            misalign_trap;
`endif

    modport master (
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  exec_done, branch, zero_flag, pc_branch,
        input  halt_req, resume,
`ifdef MISALIGN_TRAP_EN
        output misalign_trap,
`endif
        output imem_req, imem_addr, instr, instr_valid,
        output pc, pc_src, halted, fetch_err
    );

    modport slave (
        output imem_gnt, imem_rvalid, imem_rdata,
        output exec_done, branch, zero_flag, pc_branch,
        output halt_req, resume,
`ifdef MISALIGN_TRAP_EN
        input  misalign_trap,
`endif
        input  imem_req, imem_addr, instr, instr_valid,
        input  pc, pc_src, halted, fetch_err
    );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_sequencer
// Description : Owns the architectural PC and sequences one instruction at a
//               time: fetch request -> memory response -> execute -> next-PC.
//               Configuration macro: MISALIGN_TRAP_EN
//                 defined   : a taken branch to a non word-aligned target
//                             leaves pc unchanged, halts and raises the
//                             sticky misalign_trap output.
//                 undefined : the branch target is word-aligned by forcing
//                             bits [1:0] to zero; no trap output exists.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk    in  single clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    pc_fetch_sequencer_if.master (memory handshake, datapath framing,
//          run control; see the interface file for the signal list)
// Parameters:
//   XLEN         address / data width
//   RESET_PC     PC loaded on reset
//   TIMEOUT_CYC  max cycles waiting for imem_rvalid before a fault; 0 = off
// ============================================================================
module pc_fetch_sequencer #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              TIMEOUT_CYC = 255
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    pc_fetch_sequencer_if.master bus
);

    // Counter only needs to reach TIMEOUT_CYC-1.
    localparam int                c_CNT_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam bit                c_TIMEOUT_EN = (TIMEOUT_CYC != 0);
    localparam logic [XLEN-1:0]   c_PC_STEP    = XLEN'(4);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t             r_state,     w_state_nxt;
    logic [XLEN-1:0]    r_pc,        w_pc_nxt;
    logic [31:0]        r_instr,     w_instr_nxt;
    logic               r_pc_src,    w_pc_src_nxt;
    logic [c_CNT_W-1:0] r_cnt,       w_cnt_nxt;
    logic               r_fetch_err, w_fetch_err_nxt;
`ifdef MISALIGN_TRAP_EN
    logic               r_trap,      w_trap_nxt;
`endif

    logic               w_taken;
    logic [XLEN-1:0]    w_pc_seq;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_instr     <= '0;
            r_pc_src    <= 1'b0;
            r_cnt       <= '0;
            r_fetch_err <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            r_trap      <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_instr     <= w_instr_nxt;
            r_pc_src    <= w_pc_src_nxt;
            r_cnt       <= w_cnt_nxt;
            r_fetch_err <= w_fetch_err_nxt;
`ifdef MISALIGN_TRAP_EN
            r_trap      <= w_trap_nxt;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_instr_nxt     = r_instr;
        w_pc_src_nxt    = r_pc_src;
        w_cnt_nxt       = r_cnt;
        w_fetch_err_nxt = r_fetch_err;
`ifdef MISALIGN_TRAP_EN
        w_trap_nxt      = r_trap;
`endif
        w_taken  = bus.branch & bus.zero_flag;
        w_pc_seq = r_pc + c_PC_STEP;   // wraps modulo 2^XLEN

        case (r_state)
            S_IDLE: begin
                w_state_nxt = bus.halt_req ? S_HALT : S_FETCH;
            end

            S_FETCH: begin
                // halt_req is deliberately not looked at here: an issued
                // request always completes and retires first.
                if (bus.imem_gnt) begin
                    if (bus.imem_rvalid) begin
                        w_instr_nxt = bus.imem_rdata;
                        w_state_nxt = S_EXEC;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    w_instr_nxt = bus.imem_rdata;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_EXEC;
                end else if (c_TIMEOUT_EN && (r_cnt == c_CNT_LAST)) begin
                    // PC is left alone so resume re-fetches the same address.
                    w_fetch_err_nxt = 1'b1;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = S_HALT;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_EXEC: begin
                if (bus.exec_done) begin
                    w_pc_src_nxt = w_taken;
`ifdef MISALIGN_TRAP_EN
                    if (w_taken && (bus.pc_branch[1:0] != 2'b00)) begin
                        w_trap_nxt  = 1'b1;
                        w_state_nxt = S_HALT;
                    end else begin
                        w_pc_nxt    = w_taken ? bus.pc_branch : w_pc_seq;
                        w_state_nxt = bus.halt_req ? S_HALT : S_FETCH;
                    end
`else
                    w_pc_nxt    = w_taken ? {bus.pc_branch[XLEN-1:2], 2'b00} : w_pc_seq;
                    w_state_nxt = bus.halt_req ? S_HALT : S_FETCH;
`endif
                end
            end

            S_HALT: begin
                // resume has priority over a concurrent halt_req; the halt
                // request then takes effect at the next retirement.
                if (bus.resume) begin
                    w_fetch_err_nxt = 1'b0;
`ifdef MISALIGN_TRAP_EN
                    w_trap_nxt      = 1'b0;
`endif
                    w_state_nxt     = S_FETCH;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from registered state
    // ------------------------------------------------------------------
    assign bus.imem_req    = (r_state == S_FETCH);
    assign bus.imem_addr   = r_pc;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = (r_state == S_EXEC);
    assign bus.pc          = r_pc;
    assign bus.pc_src      = r_pc_src;
    assign bus.halted      = (r_state == S_HALT);
    assign bus.fetch_err   = r_fetch_err;
`ifdef MISALIGN_TRAP_EN
    assign bus.misalign_trap = r_trap;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_fetch_sequencer
// Description : Directed self-checking bench for pc_fetch_sequencer
//               (RESET_PC=0x100, TIMEOUT_CYC=4). Honours MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_fetch_sequencer;

    localparam int XLEN = 32;

    logic clk;
    logic rst_n;

    int n_total;
    int n_bad;
    logic [31:0] e_pc;

    pc_fetch_sequencer_if #(.XLEN(XLEN)) bus ();

    pc_fetch_sequencer #(
        .XLEN        (XLEN),
        .RESET_PC    (32'h0000_0100),
        .TIMEOUT_CYC (4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.exec_done   = 1'b0;
        bus.branch      = 1'b0;
        bus.zero_flag   = 1'b0;
        bus.resume      = 1'b0;
    endtask

    // Bounded wait for imem_req; an expired bound is a failed comparison.
    task automatic wait_req(input string tag);
        int k;
        k = 0;
        while (bus.imem_req !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        chk(tag, {31'd0, bus.imem_req}, 32'd1);
    endtask

    // Zero-wait fetch of word w, then retire with the given branch inputs.
    task automatic run_instr(input logic [31:0] w, input logic br, input logic zf,
                             input logic [31:0] tgt);
        bus.imem_gnt    = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = w;
        step();
        idle_inputs();
        bus.exec_done = 1'b1;
        bus.branch    = br;
        bus.zero_flag = zf;
        bus.pc_branch = tgt;
        step();
        idle_inputs();
    endtask

    initial begin
        n_total        = 0;
        n_bad          = 0;
        rst_n          = 1'b0;
        idle_inputs();
        bus.imem_rdata = 32'h0;
        bus.pc_branch  = 32'h0;
        bus.halt_req   = 1'b0;

        // ---------------- reset state ----------------
        step();
        chk("rst_pc",          bus.pc,                     32'h100);
        chk("rst_req",         {31'd0, bus.imem_req},      32'd0);
        chk("rst_valid",       {31'd0, bus.instr_valid},   32'd0);
        chk("rst_halted",      {31'd0, bus.halted},        32'd0);
        chk("rst_err",         {31'd0, bus.fetch_err},     32'd0);
        rst_n = 1'b1;

        // ---------------- 1: zero-wait fetch at RESET_PC ----------------
        wait_req("t1_req");
        chk("t1_addr", bus.imem_addr, 32'h100);
        bus.imem_gnt    = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
        step();
        idle_inputs();
        chk("t1_valid", {31'd0, bus.instr_valid}, 32'd1);
        chk("t1_instr", bus.instr, 32'hDEAD_BEEF);
        // exec_done withheld: instr_valid must hold
        step();
        chk("t1_hold", {31'd0, bus.instr_valid}, 32'd1);
        bus.exec_done = 1'b1;
        step();
        idle_inputs();
        chk("t1_pc",     bus.pc,                 32'h104);
        chk("t1_pcsrc",  {31'd0, bus.pc_src},    32'd0);
        chk("t1_addr2",  bus.imem_addr,          32'h104);

        // ---------------- 2: gnt then rvalid, taken / not-taken branch ----------------
        bus.imem_gnt = 1'b1;
        step();
        idle_inputs();
        chk("t2_wait_req",   {31'd0, bus.imem_req},    32'd0);
        chk("t2_wait_valid", {31'd0, bus.instr_valid}, 32'd0);
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h1111_1111;
        step();
        idle_inputs();
        chk("t2_valid", {31'd0, bus.instr_valid}, 32'd1);
        chk("t2_instr", bus.instr, 32'h1111_1111);
        bus.exec_done = 1'b1;
        bus.branch    = 1'b1;
        bus.zero_flag = 1'b1;
        bus.pc_branch = 32'h40;
        step();
        idle_inputs();
        chk("t2_taken_pc",    bus.pc,              32'h40);
        chk("t2_taken_pcsrc", {31'd0, bus.pc_src}, 32'd1);
        run_instr(32'h2, 1'b1, 1'b0, 32'h80);
        chk("t2_nt_pc",    bus.pc,              32'h44);
        chk("t2_nt_pcsrc", {31'd0, bus.pc_src}, 32'd0);

        // ---------------- 3: pc wrap ----------------
        run_instr(32'h3, 1'b1, 1'b1, 32'hFFFF_FFFC);
        chk("t3_pc_top", bus.pc, 32'hFFFF_FFFC);
        run_instr(32'h4, 1'b0, 1'b0, 32'h0);
        chk("t3_wrap_pc",   bus.pc,        32'h0);
        chk("t3_wrap_addr", bus.imem_addr, 32'h0);

        // ---------------- 6: misaligned taken branch ----------------
        run_instr(32'h5, 1'b1, 1'b1, 32'h42);
`ifdef MISALIGN_TRAP_EN
        chk("t6_trap_pc",   bus.pc,                      32'h0);
        chk("t6_trap",      {31'd0, bus.misalign_trap},  32'd1);
        chk("t6_halted",    {31'd0, bus.halted},         32'd1);
        bus.resume = 1'b1;
        step();
        idle_inputs();
        chk("t6_trap_clr",  {31'd0, bus.misalign_trap},  32'd0);
        e_pc = 32'h0;
`else
        chk("t6_align_pc",  bus.pc, 32'h40);
        e_pc = 32'h40;
`endif
        chk("t6_req", {31'd0, bus.imem_req}, 32'd1);

        // ---------------- 4: fetch timeout ----------------
        bus.imem_gnt = 1'b1;
        step();
        idle_inputs();
        step();
        step();
        step();
        chk("t4_not_yet", {31'd0, bus.halted}, 32'd0);
        step();
        chk("t4_halted", {31'd0, bus.halted},    32'd1);
        chk("t4_err",    {31'd0, bus.fetch_err}, 32'd1);
        chk("t4_noreq",  {31'd0, bus.imem_req},  32'd0);
        // late rvalid in HALT is ignored
        bus.imem_rvalid = 1'b1;
        step();
        idle_inputs();
        chk("t4_still_halt", {31'd0, bus.halted}, 32'd1);
        bus.resume = 1'b1;
        step();
        idle_inputs();
        chk("t4_err_clr", {31'd0, bus.fetch_err}, 32'd0);
        chk("t4_refetch", bus.imem_addr, e_pc);
        chk("t4_req",     {31'd0, bus.imem_req}, 32'd1);

        // ---------------- 5: halt_req during WAIT, then async reset ----------------
        bus.imem_gnt = 1'b1;
        step();
        idle_inputs();
        bus.halt_req = 1'b1;
        step();
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'h2222_2222;
        step();
        idle_inputs();
        chk("t5_valid", {31'd0, bus.instr_valid}, 32'd1);
        chk("t5_instr", bus.instr, 32'h2222_2222);
        bus.exec_done = 1'b1;
        step();
        idle_inputs();
        bus.halt_req = 1'b0;
        chk("t5_halted", {31'd0, bus.halted}, 32'd1);
        chk("t5_pc",     bus.pc, e_pc + 32'd4);
        step();
        step();
        chk("t5_noreq",  {31'd0, bus.imem_req}, 32'd0);
        bus.resume = 1'b1;
        step();
        idle_inputs();
        bus.imem_gnt = 1'b1;
        step();
        idle_inputs();
        chk("t5_in_wait", {31'd0, bus.imem_req}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_pc",     bus.pc,                   32'h100);
        chk("t5_rst_instr",  bus.instr,                32'h0);
        chk("t5_rst_req",    {31'd0, bus.imem_req},    32'd0);
        chk("t5_rst_valid",  {31'd0, bus.instr_valid}, 32'd0);
        chk("t5_rst_halted", {31'd0, bus.halted},      32'd0);
        chk("t5_rst_err",    {31'd0, bus.fetch_err},   32'd0);
        chk("t5_rst_pcsrc",  {31'd0, bus.pc_src},      32'd0);
        step();
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
